// File: rtl/full_adder_4bit_sync.sv
// full_adder_4bit_sync: registered 4-bit ripple-carry adder with carry-in,
// carry-out, valid, signed-overflow and zero flags (one-cycle latency).
module full_adder_4bit_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       out_valid,
    output logic       ovf,
    output logic       zero
);
    logic [4:0] c;
    logic [3:0] s;
    logic [3:0] sum_d, sum_q;
    logic       cout_d, cout_q;
    logic       ovf_d, ovf_q;
    logic       zero_d, zero_q;
    logic       out_valid_d, out_valid_q;

    always_comb begin
        c[0] = Cin;
        s    = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    // Result registers hold while idle; only out_valid drops back to 0.
    always_comb begin
        sum_d       = in_valid ? s : sum_q;
        cout_d      = in_valid ? c[4] : cout_q;
        ovf_d       = in_valid ? ((A[3] == B[3]) && (s[3] != A[3])) : ovf_q;
        zero_d      = in_valid ? (s == 4'b0000) : zero_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_full_adder_4bit_sync.sv
// tb_full_adder_4bit_sync: directed, exhaustive and random checks of the
// registered adder against an arithmetic reference model.
module tb_full_adder_4bit_sync;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       Cin = 1'b0;
    logic [3:0] Sum;
    logic       Cout, out_valid, ovf, zero;

    int total = 0;
    int bad = 0;

    logic [3:0] m_sum = '0;
    logic       m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0, m_valid = 1'b0;

    full_adder_4bit_sync dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A(A), .B(B), .Cin(Cin),
        .Sum(Sum), .Cout(Cout), .out_valid(out_valid), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic; signed overflow from signed range.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [3:0] a, input logic [3:0] b, input logic ci);
        int u, sg;
        rst_n = r; in_valid = v; A = a; B = b; Cin = ci;
        u  = int'(a) + int'(b) + int'(ci);
        sg = int'($signed(a)) + int'($signed(b)) + int'(ci);
        if (!r) begin
            m_sum = '0; m_cout = 0; m_ovf = 0; m_zero = 0; m_valid = 0;
        end else if (v) begin
            m_sum = u[3:0]; m_cout = (u >= 16); m_ovf = (sg > 7 || sg < -8);
            m_zero = (u % 16 == 0); m_valid = 1;
        end else
            m_valid = 0;
        @(posedge clk);
        #1;
        check({tag, ".sum"}, {1'b0, Sum}, {1'b0, m_sum});
        check({tag, ".cout"}, {4'b0, Cout}, {4'b0, m_cout});
        check({tag, ".ovf"}, {4'b0, ovf}, {4'b0, m_ovf});
        check({tag, ".zero"}, {4'b0, zero}, {4'b0, m_zero});
        check({tag, ".vld"}, {4'b0, out_valid}, {4'b0, m_valid});
    endtask

    initial begin
        step("rst0", 0, 1, 4'hF, 4'hF, 1);
        step("rst1", 0, 1, 4'hF, 4'hF, 1);
        check("rst_sum_const", {1'b0, Sum}, 5'h0);
        step("rel", 1, 1, 4'hF, 4'hF, 1);
        check("rel_sum_const", {Cout, Sum}, 5'h1F);
        step("b1", 1, 1, 4'd1, 4'd2, 0);
        check("b1_const", {Cout, Sum}, 5'd3);
        step("b2", 1, 1, 4'd5, 4'd3, 1);
        check("b2_ovf_const", {4'b0, ovf}, 5'd1);
        step("wrap1", 1, 1, 4'd15, 4'd1, 0);
        check("wrap1_zero_const", {4'b0, zero}, 5'd1);
        step("wrap2", 1, 1, 4'd9, 4'd6, 1);
        step("max", 1, 1, 4'd15, 4'd15, 1);
        step("h_cap", 1, 1, 4'd1, 4'd2, 0);
        step("hold", 1, 0, 4'd7, 4'd8, 1);
        check("hold_const", {Cout, Sum}, 5'd3);
        step("hold2", 1, 0, 4'd12, 4'd13, 0);
        step("mid_rst", 0, 1, 4'd6, 4'd6, 0);
        step("post_rst", 1, 1, 4'd6, 4'd6, 0);
        for (int i = 0; i < 512; i++)
            step("exh", 1, 1, 4'(i >> 5), 4'(i >> 1), i[0]);
        for (int i = 0; i < 300; i++)
            step("rnd", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
